// File: rtl/dec_lut_sched_if.sv
// Bus bundle between the requesters, the shared LUT decoder and dec_lut_sched.
// The slave modport is the scheduler's view; master is the requester/decoder side.
interface dec_lut_sched_if #(
    parameter int W_BITS = 25,
    parameter int N_BITS = 13,
    parameter int NREQ   = 4
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*W_BITS-1:0] req_W;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [N_BITS-1:0]      rsp_N;
    logic                   rsp_hit;
    logic [W_BITS-1:0]      dec_W;
    logic                   dec_start;
    logic                   dec_found;
    logic [N_BITS-1:0]      dec_N;

    modport master (
        output req_valid, req_W, dec_found, dec_N,
        input  req_ready, rsp_valid, rsp_N, rsp_hit, dec_W, dec_start
    );

    modport slave (
        input  req_valid, req_W, dec_found, dec_N,
        output req_ready, rsp_valid, rsp_N, rsp_hit, dec_W, dec_start
    );
endinterface

// File: rtl/dec_lut_sched.sv
// Round-robin scheduler sharing one LUT decoder among NREQ requesters,
// with a per-search timeout that reports a miss when the decoder never answers.
module dec_lut_sched #(
    parameter int W_BITS  = 25,
    parameter int N_BITS  = 13,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 5000
) (
    input  logic           clk,
    input  logic           rst,
    dec_lut_sched_if.slave bus,
    output logic           busy,
    output logic [7:0]     timeout_cnt
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // First requester with valid set, scanning upward from start and wrapping.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                 input logic [PTR_W-1:0] start);
        logic [PTR_W:0]   sum;
        logic [PTR_W:0]   idx;
        logic [PTR_W-1:0] pick;
        pick = start;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum  = {1'b0, start} + (PTR_W+1)'(k);
            idx  = (sum >= (PTR_W+1)'(NREQ)) ? (sum - (PTR_W+1)'(NREQ)) : sum;
            pick = valid[idx[PTR_W-1:0]] ? idx[PTR_W-1:0] : pick;
        end
        return pick;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [PTR_W-1:0]  ptr_r, ptr_nxt_s, pick_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [NREQ-1:0]   gnt_r, gnt_nxt_s, pick_oh_s;
    logic [NREQ-1:0]   req_ready_r, req_ready_nxt_s;
    logic [NREQ-1:0]   rsp_valid_r, rsp_valid_nxt_s;
    logic [N_BITS-1:0] rsp_n_r, rsp_n_nxt_s;
    logic              rsp_hit_r, rsp_hit_nxt_s;
    logic [W_BITS-1:0] dec_w_r, dec_w_nxt_s;
    logic              dec_start_r, dec_start_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic [7:0]        timeout_cnt_r, timeout_cnt_nxt_s;
    logic              any_req_s, found_s, expire_s;
    logic [W_BITS-1:0] key_s [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_key
        assign key_s[i] = bus.req_W[i*W_BITS +: W_BITS];
    end

    assign any_req_s = |bus.req_valid;
    assign pick_s    = rr_pick(bus.req_valid, ptr_r);
    assign pick_oh_s = NREQ'(1'b1) << pick_s;
    // A completion flag seen alongside the launch pulse belongs to no search of ours.
    assign found_s   = bus.dec_found & ~dec_start_r;
    assign expire_s  = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (found_s || expire_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the arbitration/timeout datapath.
    always_comb begin
        ptr_nxt_s         = ptr_r;
        cnt_nxt_s         = cnt_r;
        gnt_nxt_s         = gnt_r;
        dec_w_nxt_s       = dec_w_r;
        timeout_cnt_nxt_s = timeout_cnt_r;
        req_ready_nxt_s   = '0;
        dec_start_nxt_s   = 1'b0;
        rsp_valid_nxt_s   = '0;
        rsp_n_nxt_s       = '0;
        rsp_hit_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    gnt_nxt_s       = pick_oh_s;
                    req_ready_nxt_s = pick_oh_s;
                    dec_w_nxt_s     = key_s[pick_s];
                    dec_start_nxt_s = 1'b1;
                    cnt_nxt_s       = '0;
                    ptr_nxt_s       = (pick_s == PTR_LAST) ? '0 : (pick_s + PTR_W'(1'b1));
                end else begin
                    gnt_nxt_s = gnt_r;
                end
            end
            ST_WAIT: begin
                cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                if (found_s) begin
                    rsp_valid_nxt_s = gnt_r;
                    rsp_n_nxt_s     = bus.dec_N;
                    rsp_hit_nxt_s   = 1'b1;
                end else if (expire_s) begin
                    rsp_valid_nxt_s   = gnt_r;
                    rsp_n_nxt_s       = '1;
                    rsp_hit_nxt_s     = 1'b0;
                    timeout_cnt_nxt_s = (timeout_cnt_r == 8'hFF) ? 8'hFF : (timeout_cnt_r + 8'd1);
                end else begin
                    rsp_valid_nxt_s = '0;
                end
            end
            ST_RESP: rsp_valid_nxt_s = '0;
            default: rsp_valid_nxt_s = '0;
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r         <= '0;
            cnt_r         <= '0;
            gnt_r         <= '0;
            dec_w_r       <= '0;
            timeout_cnt_r <= 8'd0;
            req_ready_r   <= '0;
            dec_start_r   <= 1'b0;
            rsp_valid_r   <= '0;
            rsp_n_r       <= '0;
            rsp_hit_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            ptr_r         <= ptr_nxt_s;
            cnt_r         <= cnt_nxt_s;
            gnt_r         <= gnt_nxt_s;
            dec_w_r       <= dec_w_nxt_s;
            timeout_cnt_r <= timeout_cnt_nxt_s;
            req_ready_r   <= req_ready_nxt_s;
            dec_start_r   <= dec_start_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_n_r       <= rsp_n_nxt_s;
            rsp_hit_r     <= rsp_hit_nxt_s;
            busy_r        <= busy_nxt_s;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.dec_start = dec_start_r;
    assign bus.dec_W     = dec_w_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_N     = rsp_n_r;
    assign bus.rsp_hit   = rsp_hit_r;
    assign busy          = busy_r;
    assign timeout_cnt   = timeout_cnt_r;
endmodule

// File: tb/tb_dec_lut_sched.sv
// Directed bench for dec_lut_sched: a transaction-level reference model is
// compared against every DUT output each cycle, plus hand-computed checkpoints.
module tb_dec_lut_sched;
    localparam int W_BITS  = 25;
    localparam int N_BITS  = 13;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] timeout_cnt;

    dec_lut_sched_if #(.W_BITS(W_BITS), .N_BITS(N_BITS), .NREQ(NREQ)) bus ();

    dec_lut_sched #(.W_BITS(W_BITS), .N_BITS(N_BITS), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Decoder stand-in: answers dec_delay+1 cycles after the launch cycle (-1 = never).
    int                dec_delay  = -1;
    int                dcnt       = 0;
    bit                dec_active = 1'b0;
    bit                dec_early  = 1'b0;
    bit                auto_clear = 1'b1;
    logic [N_BITS-1:0] dec_n_val  = '0;

    // Reference model: which search is outstanding, how old it is, who owns it.
    int                m_ptr, m_age, m_owner, m_timeouts;
    bit                m_active, m_cool;
    logic [NREQ-1:0]   e_ready, e_rsp_valid;
    logic              e_start, e_hit, e_busy;
    logic [W_BITS-1:0] e_dec_w;
    logic [N_BITS-1:0] e_rsp_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_age = 0; m_owner = 0; m_timeouts = 0;
        m_active = 1'b0; m_cool = 1'b0;
        e_ready = '0; e_start = 1'b0; e_dec_w = '0;
        e_rsp_valid = '0; e_rsp_n = '0; e_hit = 1'b0; e_busy = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs the DUT samples there.
    task automatic model_update();
        bit picked;
        int idx;
        e_ready = '0; e_start = 1'b0; e_rsp_valid = '0; e_rsp_n = '0; e_hit = 1'b0;
        if (m_active) begin
            if (bus.dec_found && m_age > 0) begin
                m_active = 1'b0; m_cool = 1'b1;
                e_rsp_valid[m_owner] = 1'b1;
                e_rsp_n = bus.dec_N;
                e_hit = 1'b1;
            end else if (m_age == TIMEOUT - 1) begin
                m_active = 1'b0; m_cool = 1'b1;
                e_rsp_valid[m_owner] = 1'b1;
                e_rsp_n = 13'h1FFF;
                m_timeouts = (m_timeouts < 255) ? m_timeouts + 1 : 255;
            end else begin
                m_age++;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (bus.req_valid != '0) begin
            picked = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!picked && bus.req_valid[idx]) begin
                    m_owner = idx;
                    picked = 1'b1;
                end
            end
            e_ready[m_owner] = 1'b1;
            e_start = 1'b1;
            e_dec_w = bus.req_W[m_owner*W_BITS +: W_BITS];
            m_ptr = (m_owner + 1) % NREQ;
            m_active = 1'b1;
            m_age = 0;
        end
        e_busy = m_active || m_cool;
    endtask

    task automatic compare_all();
        check("req_ready",   32'(bus.req_ready), 32'(e_ready));
        check("dec_start",   32'(bus.dec_start), 32'(e_start));
        check("dec_W",       32'(bus.dec_W),     32'(e_dec_w));
        check("rsp_valid",   32'(bus.rsp_valid), 32'(e_rsp_valid));
        check("rsp_N",       32'(bus.rsp_N),     32'(e_rsp_n));
        check("rsp_hit",     32'(bus.rsp_hit),   32'(e_hit));
        check("busy",        32'(busy),          32'(e_busy));
        check("timeout_cnt", 32'(timeout_cnt),   32'(m_timeouts));
    endtask

    // One clock: model at the edge, requester/decoder reaction after it, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_update();
        #2;
        cyc++;
        if (auto_clear) bus.req_valid = bus.req_valid & ~bus.req_ready;
        if (bus.dec_start) begin
            dec_active = 1'b1;
            dcnt = 0;
        end else if (dec_active) begin
            dcnt++;
        end
        bus.dec_found = 1'b0;
        bus.dec_N = 13'h0AA;
        if (dec_active && bus.dec_start && dec_early) begin
            bus.dec_found = 1'b1;
            bus.dec_N = 13'd5;
        end else if (dec_active && dec_delay >= 0 && dcnt == dec_delay + 1) begin
            bus.dec_found = 1'b1;
            bus.dec_N = dec_n_val;
            dec_active = 1'b0;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (bus.req_ready == '0 && n < budget) begin step(); n++; end
        check("ready_seen", 32'(bus.req_ready != '0), 32'd1);
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (bus.rsp_valid == '0 && n < budget) begin step(); n++; end
        check("rsp_seen", 32'(bus.rsp_valid != '0), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin step(); n++; end
        check("idle_seen", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] grants [5];
        logic [NREQ-1:0] exp_order [5];
        int              start_at [5];
        int              t0, stale;

        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_W = {25'd400, 25'd1234567, 25'd200, 25'd100};
        bus.dec_found = 1'b0;
        bus.dec_N = '0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tcnt", 32'(timeout_cnt), 32'd0);
        check("reset_decw", 32'(bus.dec_W), 32'd0);

        // Fairness: all four held, fastest decoder.
        auto_clear = 1'b0; dec_delay = 0; dec_n_val = 13'd11;
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ready(20);
            grants[g] = bus.req_ready;
            start_at[g] = cyc;
            step();
        end
        bus.req_valid = '0; auto_clear = 1'b1;
        wait_idle(40);
        for (int g = 0; g < 5; g++) check("rr_order", 32'(grants[g]), 32'(exp_order[g]));
        for (int g = 1; g < 5; g++) check("dstart_gap", 32'(start_at[g] - start_at[g-1] - 1), 32'd3);

        // Single requester 2, found after 10 search cycles.
        dec_delay = 10; dec_n_val = 13'd4095;
        bus.req_valid = 4'b0100; t0 = cyc;
        wait_ready(20);
        check("single_ready", 32'(bus.req_ready), 32'h4);
        check("single_decw", 32'(bus.dec_W), 32'd1234567);
        check("single_start", 32'(bus.dec_start), 32'd1);
        wait_rsp(40);
        check("single_rspv", 32'(bus.rsp_valid), 32'h4);
        check("single_hit", 32'(bus.rsp_hit), 32'd1);
        check("single_n", 32'(bus.rsp_N), 32'd4095);
        check("single_latency", 32'(cyc - t0), 32'd13);
        check("single_decw_held", 32'(bus.dec_W), 32'd1234567);
        wait_idle(10);

        // Timeout: decoder silent, requester 0 wins after wrapping from pointer 3.
        dec_delay = -1;
        bus.req_valid = 4'b0001;
        wait_ready(20);
        check("tmo_ready", 32'(bus.req_ready), 32'h1);
        t0 = cyc;
        wait_rsp(40);
        check("tmo_hit", 32'(bus.rsp_hit), 32'd0);
        check("tmo_n", 32'(bus.rsp_N), 32'h1FFF);
        check("tmo_delay", 32'(cyc - t0), 32'd16);
        check("tmo_cnt", 32'(timeout_cnt), 32'd1);
        wait_idle(10);

        // Completion flag during the launch cycle only must be ignored.
        dec_early = 1'b1;
        bus.req_valid = 4'b1000;
        wait_ready(20);
        wait_rsp(40);
        check("early_hit", 32'(bus.rsp_hit), 32'd0);
        check("early_cnt", 32'(timeout_cnt), 32'd2);
        dec_early = 1'b0;
        wait_idle(10);

        // Race: found arrives in the last wait cycle.
        dec_delay = 14; dec_n_val = 13'd7;
        bus.req_valid = 4'b0010;
        wait_ready(20);
        t0 = cyc;
        wait_rsp(40);
        check("race_hit", 32'(bus.rsp_hit), 32'd1);
        check("race_n", 32'(bus.rsp_N), 32'd7);
        check("race_delay", 32'(cyc - t0), 32'd16);
        check("race_cnt", 32'(timeout_cnt), 32'd2);
        wait_idle(10);

        // Reset mid-WAIT; pointer is 2 so requester 3 wins first.
        dec_delay = 10; dec_n_val = 13'd9;
        bus.req_valid = 4'b1001;
        wait_ready(20);
        check("pre_rst_ready", 32'(bus.req_ready), 32'h8);
        repeat (5) step();
        bus.req_valid = '0;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_tcnt", 32'(timeout_cnt), 32'd0);
        step();
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.rsp_valid != '0) stale++;
        end
        check("stale_rsp", 32'(stale), 32'd0);
        bus.req_valid = 4'b1100;
        wait_ready(20);
        check("post_rst_ready", 32'(bus.req_ready), 32'h4);
        wait_rsp(40);
        check("post_rst_n", 32'(bus.rsp_N), 32'd9);
        wait_idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dec_lut_sched.md
DEC_LUT_SCHED -- requirements
Module: dec_lut_sched

Interface
REQ-001 Parameter W_BITS, default 25, search key width driven to the LUT decoder.
REQ-002 Parameter N_BITS, default 13, decoder result width.
REQ-003 Parameter NREQ, default 4, number of requesters sharing one decoder.
REQ-004 Parameter TIMEOUT, default 5000, maximum WAIT cycles before a search is declared a miss.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_valid  input  NREQ  per-requester search request; held with req_W until req_ready.
REQ-008 req_W  input  NREQ*W_BITS  per-requester key; slice i = bits [i*W_BITS +: W_BITS].
REQ-009 req_ready  output  NREQ  one-hot, one-cycle accept pulse to the granted requester.
REQ-010 rsp_valid  output  NREQ  one-hot, one-cycle response pulse to the granted requester.
REQ-011 rsp_N  output  N_BITS  result of the completed search; valid while rsp_valid is nonzero.
REQ-012 rsp_hit  output  1  1 = decoder found the key, 0 = timeout miss; valid with rsp_valid.
REQ-013 dec_W  output  W_BITS  key to the decoder; held stable from launch until response.
REQ-014 dec_start  output  1  one-cycle pulse starting a decoder search.
REQ-015 dec_found  input  1  decoder completion flag.
REQ-016 dec_N  input  N_BITS  decoder result, valid when dec_found=1.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 timeout_cnt  output  8  saturating count of timed-out searches.

Function
REQ-019 FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-020 IDLE, any req_valid set: round-robin winner g = first set bit at or after pointer ptr (wrapping); at that edge req_ready<=onehot(g), dec_W<=req_W slice g, dec_start<=1, wait counter<=0, ptr<=(g+1) mod NREQ, state<=WAIT.
REQ-021 IDLE, no req_valid: outputs hold 0 (dec_W holds last value), ptr unchanged.
REQ-022 req_ready and dec_start are high exactly one cycle (first WAIT cycle); both 0 otherwise.
REQ-023 WAIT: counter increments every cycle; dec_found ignored in the cycle dec_start is high.
REQ-024 WAIT, dec_found=1 (dec_start low): rsp_N<=dec_N, rsp_hit<=1, rsp_valid<=onehot(g), state<=RESP.
REQ-025 WAIT, counter = TIMEOUT-1 and dec_found=0: rsp_N<=all ones, rsp_hit<=0, rsp_valid<=onehot(g), timeout_cnt +1 saturating at 255, state<=RESP.
REQ-026 dec_found and timeout in the same cycle: found wins, timeout_cnt unchanged.
REQ-027 RESP lasts one cycle with rsp_valid high, then IDLE; rsp_valid returns to 0; next grant is sampled no earlier than the IDLE cycle.
REQ-028 Requester dropping req_valid before req_ready: withdrawn, never granted; req_valid changes during WAIT/RESP ignored.
REQ-029 Request-to-response latency = decoder search cycles + 3; minimum spacing between successive dec_start pulses = 3 cycles.
REQ-030 Only one search outstanding; dec_W constant from dec_start to the RESP cycle inclusive.

Reset
REQ-031 rst=1 asynchronously forces state IDLE, ptr=0, counter=0, timeout_cnt=0, and req_ready, rsp_valid, rsp_N, rsp_hit, dec_W, dec_start, busy to 0.
REQ-032 Reset during WAIT/RESP abandons the search; no rsp_valid is issued for it after release.
REQ-033 First arbitration after release starts from requester 0.

Verification
REQ-034 Single: req_valid=4'b0100, req_W slice2=25'd1234567, decoder returns found with N=4095 after 10 cycles -> req_ready=4'b0100 one cycle, dec_W=1234567, rsp_valid=4'b0100, rsp_hit=1, rsp_N=4095, latency 13.
REQ-035 Fairness: req_valid=4'b1111 held, re-asserted after each accept -> grant order 0,1,2,3,0; no requester granted twice within four grants.
REQ-036 Timeout: TIMEOUT=16, decoder never asserts dec_found -> rsp_hit=0, rsp_N=13'h1FFF 16 cycles after dec_start, timeout_cnt=1.
REQ-037 Race: dec_found first asserted in the counter=TIMEOUT-1 cycle with dec_N=7 -> rsp_hit=1, rsp_N=7, timeout_cnt unchanged.
REQ-038 Reset mid-WAIT: rst pulsed 5 cycles after dec_start, decoder later asserts dec_found -> all outputs 0, no rsp_valid, next grant to lowest set req_valid bit.
